// File: rtl/s_mem_checker.sv
// s_mem_checker: reads back the S memory and checks every location holds its own address
module s_mem_checker #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  output logic              rden,
  input  logic [ADDR_W-1:0] rddata,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] err_addr
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAXC  = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]        DLAST = 2'(RD_LAT - 1);
  state_t state, state_d;
  logic [1:0] dcnt;
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0][ADDR_W-1:0] pa;
  logic start, mis, ferr;
  logic [ADDR_W:0] cnt_d;
  assign rdy  = state == IDLE;
  assign rden = state == READ;
  assign done = state == FIN;
  // next state, start detect and the compare result of the oldest pipeline entry
  always_comb begin
    state_d = state;
    start = state == IDLE && en;
    mis = vld[RD_LAT-1] && rddata != pa[RD_LAT-1];
    cnt_d = mis && err_count != MAXC ? err_count + 1'b1 : err_count;
    if (start) state_d = READ;
    if (state == READ && addr == LAST) state_d = DRAIN;
    if (state == DRAIN && dcnt == DLAST) state_d = FIN;
    if (state == FIN) state_d = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // address counter, drain counter and the expected-value shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      dcnt <= '0;
      vld <= '0;
      pa <= '0;
    end else begin
      addr <= start ? '0 : state == READ && addr != LAST ? addr + 1'b1 : addr;
      dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
      vld[0] <= rden;
      pa[0] <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
  // scan results: cleared on start, updated per compare, pass decided on entry to FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      err_addr <= '0;
      ferr <= 1'b0;
      pass <= 1'b0;
    end else if (start) begin
      err_count <= '0;
      err_addr <= '0;
      ferr <= 1'b0;
      pass <= 1'b0;
    end else begin
      err_count <= cnt_d;
      if (mis && !ferr) begin
        err_addr <= pa[RD_LAT-1];
        ferr <= 1'b1;
      end
      if (state == DRAIN && state_d == FIN) pass <= cnt_d == '0;
    end
  end
endmodule

// File: tb/tb_s_mem_checker.sv
// tb_s_mem_checker: directed scans of the S-memory checker at read latency 1 and 2
module tb_s_mem_checker;
  logic clk = 0, rst_n = 0, en = 0, sel = 0;
  logic [7:0] mem [256];
  logic rdy1, rden1, done1, pass1, rdy2, rden2, done2, pass2;
  logic [7:0] addr1, addr2, ea1, ea2, rd1, rd2, r2a;
  logic [8:0] cnt1, cnt2;
  logic en1, en2;
  logic rdy_s, rden_s, done_s, pass_s;
  logic [7:0] addr_s, ea_s;
  logic [8:0] cnt_s;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign en1 = en && !sel;
  assign en2 = en && sel;
  assign rdy_s = sel ? rdy2 : rdy1;
  assign rden_s = sel ? rden2 : rden1;
  assign done_s = sel ? done2 : done1;
  assign pass_s = sel ? pass2 : pass1;
  assign addr_s = sel ? addr2 : addr1;
  assign ea_s = sel ? ea2 : ea1;
  assign cnt_s = sel ? cnt2 : cnt1;
  s_mem_checker #(.DEPTH(256), .ADDR_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .addr(addr1), .rden(rden1),
    .rddata(rd1), .done(done1), .pass(pass1), .err_count(cnt1), .err_addr(ea1));
  s_mem_checker #(.DEPTH(256), .ADDR_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .rdy(rdy2), .addr(addr2), .rden(rden2),
    .rddata(rd2), .done(done2), .pass(pass2), .err_count(cnt2), .err_addr(ea2));
  always @(posedge clk) begin
    if (rden1) rd1 <= mem[addr1];
    if (rden2) r2a <= mem[addr2];
    rd2 <= r2a;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic fill_identity();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask
  task automatic run_scan(input bit s, input int exp_lat, input int exp_cnt, input int exp_ea,
                          input int exp_pass, input int re_at, input string tag);
    int n, dn, dat, rc;
    bit bad;
    logic pd;
    sel = s;
    @(negedge clk);
    en = 1;
    @(posedge clk);
    #1 en = 0;
    n = 0; dn = 0; dat = -1; rc = 0; bad = 0; pd = 1'bx;
    while (!rdy_s && n < 1000) begin
      if (rden_s) begin
        if (int'(addr_s) != rc) bad = 1;
        if (int'(addr_s) == re_at) en = 1;
        rc++;
      end
      if (done_s) begin
        dn++;
        dat = n;
        pd = pass_s;
      end
      @(posedge clk);
      #1 en = 0;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_done_pulses"}, dn, 1);
    check({tag, "_done_cycle"}, dat, exp_lat - 1);
    check({tag, "_addr_seq_bad"}, 32'(bad), 0);
    check({tag, "_rden_cycles"}, rc, 256);
    check({tag, "_pass_at_done"}, 32'(pd), exp_pass);
    check({tag, "_pass"}, 32'(pass_s), exp_pass);
    check({tag, "_err_count"}, 32'(cnt_s), exp_cnt);
    check({tag, "_err_addr"}, 32'(ea_s), exp_ea);
  endtask
  initial begin
    int n, dn;
    fill_identity();
    #12;
    check("reset_rdy", 32'(rdy1), 1);
    check("reset_addr", 32'(addr1), 0);
    check("reset_rden", 32'(rden1), 0);
    check("reset_done", 32'(done1), 0);
    check("reset_pass", 32'(pass1), 0);
    check("reset_err_count", 32'(cnt1), 0);
    check("reset_err_addr", 32'(ea1), 0);
    @(negedge clk);
    rst_n = 1;
    run_scan(0, 258, 0, 0, 1, -1, "clean");
    repeat (3) @(posedge clk);
    #1 check("clean_pass_held", 32'(pass1), 1);
    mem[8'h5A] = 8'h00;
    run_scan(0, 258, 1, 8'h5A, 0, -1, "single");
    fill_identity();
    mem[8'h03] = 8'h10;
    mem[8'hFF] = 8'h00;
    run_scan(0, 258, 2, 8'h03, 0, -1, "double");
    fill_identity();
    run_scan(0, 258, 0, 0, 1, -1, "fixed");
    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    run_scan(0, 258, 256, 0, 0, -1, "inverted");
    fill_identity();
    run_scan(0, 258, 0, 0, 1, 8'h20, "ignore_en");
    mem[8'h10] = 8'h00;
    sel = 0;
    @(negedge clk);
    en = 1;
    @(posedge clk);
    #1 en = 0;
    n = 0; dn = 0;
    while (!(rden1 && addr1 == 8'h40) && n < 1000) begin
      if (done1) dn++;
      @(posedge clk);
      #1 n++;
    end
    check("rst_reach_0x40", n, 8'h40);
    check("pre_rst_err_count", 32'(cnt1), 1);
    rst_n = 0;
    #1;
    check("rst_rdy", 32'(rdy1), 1);
    check("rst_addr", 32'(addr1), 0);
    check("rst_rden", 32'(rden1), 0);
    check("rst_err_count", 32'(cnt1), 0);
    repeat (2) begin
      @(posedge clk);
      #1 if (done1) dn++;
    end
    check("rst_no_done", dn, 0);
    @(negedge clk);
    rst_n = 1;
    fill_identity();
    run_scan(0, 258, 0, 0, 1, -1, "after_rst");
    mem[8'hFF] = 8'h7E;
    run_scan(1, 259, 1, 8'hFF, 0, -1, "lat2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/s_mem_checker.md
Name: s_mem_checker

Overview:
- Read-side counterpart of the S-memory initialiser in the RC4 datapath.
- The initialiser writes s[i] = i into the 256-byte S memory. This block reads the memory back and checks every location against its identity value.
- Reports pass/fail, the number of errors and the first mismatching address.
- Sits beside the init module on the shared S-memory read port. Top-level control uses it as a self-check before key scheduling starts.
- Uses the same rdy/en handshake as the other RC4 sub-blocks.

Parameters:
- DEPTH, 256, number of locations scanned (addresses 0..DEPTH-1); must be a power of 2.
- ADDR_W, 8, address and data width; DEPTH = 2**ADDR_W.
- RD_LAT, 1, memory read latency in cycles, from the cycle addr/rden are presented to the cycle rddata is valid; legal values 1 or 2.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- rst_n  in  1  asynchronous active-low reset (KEY[3] at top level).
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- addr  out  ADDR_W  S-memory read address.
- rden  out  1  read enable to the S memory.
- rddata  in  ADDR_W  S-memory read data.
- done  out  1  one-cycle pulse when a scan completes.
- pass  out  1  1 if the last completed scan had zero mismatches; held until the next en.
- err_count  out  ADDR_W+1  mismatch count of the last or current scan (0..DEPTH).
- err_addr  out  ADDR_W  address of the first mismatch in the last scan; 0 if none.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, rdy=1, addr=0, rden=0, done=0, pass=0, err_count=0, err_addr=0.
  - In-flight compare pipeline entries are cleared.
  - Reset mid-scan abandons the scan with no done pulse; the next en restarts from address 0.
- States: IDLE, READ, DRAIN, FIN.
- IDLE:
  - rdy=1, rden=0.
  - en=1 at a clock edge: go to READ; rdy=0, addr=0, rden=1; clear err_count, err_addr, pass and the internal first-error flag.
- READ:
  - rden=1; addr increments by 1 every cycle.
  - The cycle addr=DEPTH-1 is presented is the last READ cycle; the next state is DRAIN with rden=0.
  - addr stays at DEPTH-1 and does not wrap.
- Compare pipeline:
  - Address a presented in cycle c has its rddata sampled at the end of cycle c+RD_LAT. It is compared against the expected value a, carried through an RD_LAT-deep shift register alongside a valid bit.
  - On mismatch: err_count increments (saturates at DEPTH, never wraps).
  - On the first mismatch of a scan: err_addr is loaded with a; later mismatches do not change err_addr.
  - Simultaneous address issue and compare in one cycle is normal operation; both proceed.
- DRAIN: waits RD_LAT cycles until the last valid compare is processed, then goes to FIN.
- FIN (one cycle):
  - done=1; pass = (err_count==0), using the final count including the last compare.
  - Next state IDLE with rdy=1.
- Latency: with en accepted at edge E0, rdy returns to 1 exactly DEPTH+RD_LAT+1 cycles after E0. The done pulse occurs in the cycle immediately before rdy rises.
- en while rdy=0 is ignored: no restart, no effect on results.
- en held high continuously starts a new scan on the first cycle back in IDLE.
- Results (pass, err_count, err_addr) remain stable from FIN until the next accepted en.
- No combinational path from rddata or en to any output.

Test Plan:
- Memory preloaded s[i]=i, RD_LAT=1, pulse en -> one done pulse, pass=1, err_count=0, err_addr=0; rdy high again exactly 258 cycles after the en edge; addr sequence 0..255 with rden high for exactly 256 cycles.
- s[0x5A]=0x00, all others identity -> pass=0, err_count=1, err_addr=0x5A.
- s[0x03]=0x10, s[0xFF]=0x00 -> err_count=2, err_addr=0x03 (first mismatch kept). Second scan after fixing memory -> pass=1, err_count=0, err_addr=0.
- s[i]=~i for all i -> err_count=256 (0x100), err_addr=0x00, pass=0.
- Pulse en, pulse en again at addr=0x20 -> ignored, single scan, single done. Then assert rst_n=0 at addr=0x40 -> immediate rdy=1, addr=0, err_count=0, no done. New en -> clean scan from address 0.
- RD_LAT=2 with a 2-cycle memory model, s[0xFF] corrupted -> err_count=1, err_addr=0xFF; rdy rises 259 cycles after the en edge.
